lsu_dmem_ctrl: RTL and testbench
================================

Name: lsu_dmem_ctrl

Overview:
- Data-memory side of the core's load/store stall handshake; it produces the `valid` that the program counter waits on while `load` or `store` is high.
- Accepts one load/store per instruction from the execute stage and handles byte/half/word alignment, write strobes and load sign/zero extension.
- Drives a variable-latency req/ack data-memory port and returns a one-cycle `valid` pulse when the access completes, faults, or times out.

Parameters:
- TIMEOUT, 16, maximum cycles to wait for mem_ack before aborting with bus_err; legal range 1..255.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous active-low reset
- load  in  1  execute stage holds a load; stays high until valid
- store  in  1  execute stage holds a store; stays high until valid
- funct3  in  3  RV32I width/sign code of the current load/store
- addr  in  32  effective byte address
- store_data  in  32  rs2 value, right-aligned
- valid  out  1  one-cycle completion pulse to pc/core
- load_data  out  32  extended load result; meaningful when valid and load
- misaligned  out  1  fault flag, qualified by valid
- bus_err  out  1  illegal funct3 or timeout, qualified by valid
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, {addr[31:2],2'b00}
- mem_wstrb  out  4  byte write enables
- mem_wdata  out  32  lane-shifted store data
- mem_rdata  in  32  read word, valid with mem_ack
- mem_ack  in  1  one-cycle acknowledge from memory

Behaviour:
- Reset (rst low, async): state IDLE; valid, misaligned, bus_err, mem_req, mem_we = 0; load_data, mem_addr, mem_wdata = 0; mem_wstrb = 0; wait counter = 0.
- FSM states: IDLE, REQ, RESP.
- IDLE, (load|store)=1:
  - Latch addr, funct3, store_data and the op. If both load and store are high, store wins.
  - Misalignment: halfword with addr[0]=1, or word with addr[1:0]≠0. Go to RESP with misaligned=1 and no memory access.
  - Illegal funct3: loads accept only 000, 001, 010, 100, 101; stores accept only 000, 001, 010. Go to RESP with bus_err=1 and no memory access.
  - Otherwise go to REQ with mem_req=1 registered.
- REQ:
  - mem_req, mem_we, mem_addr, mem_wstrb and mem_wdata are held stable until mem_ack.
  - On mem_ack: drop mem_req next edge, register the load result, go to RESP.
  - Counter increments each REQ cycle without ack. When the counter reaches TIMEOUT: drop mem_req, set bus_err, go to RESP. A late ack after abort is ignored.
- RESP: valid=1 for exactly one cycle, together with load_data, misaligned and bus_err. Next state is IDLE; the flags clear when valid drops.
- Latency: request seen at edge N, mem_req high after N, ack at N+1, valid high after N+2. Minimum 2 cycles; fault path 1 cycle (valid after N+1).
- Back-to-back: load/store high in IDLE the cycle after valid is a new instruction and is accepted normally. There is no dead cycle beyond the IDLE sample.
- Store lanes: SB: wstrb = 1<<addr[1:0], data byte replicated ×4. SH: wstrb = 0011 or 1100 by addr[1], halfword replicated ×2. SW: 1111.
- Load extract: the byte/half is selected by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- For stores, load_data stays 0. On faults, load_data = 0 and the memory port is never touched.
- Reset asserted mid-REQ aborts immediately: mem_req drops asynchronously and no valid is produced.
- load/store deasserting while in REQ (core flush) does not cancel the access; the request completes and valid still pulses.

Test Plan:
- LW addr=0x100, mem_rdata=0xDEADBEEF, ack 3 cycles after mem_req -> mem_addr=0x100, mem_we=0; valid one cycle with load_data=0xDEADBEEF; mem_req high exactly 3 cycles.
- LB addr=0x103, rdata=0x80FF_0000; then LBU same address -> load_data=0xFFFFFF80 for LB, then 0x00000080 for LBU. Back-to-back with no idle gap beyond the IDLE sample.
- SH addr=0x202, store_data=0x0000ABCD -> mem_we=1, mem_addr=0x200, mem_wstrb=1100, mem_wdata=0xABCDABCD; valid after ack; load_data=0.
- LW addr=0x101; then SH addr=0x3 -> valid one cycle after request, misaligned=1, mem_req never asserts.
- LW with TIMEOUT=16 and mem_ack never asserted -> mem_req high 16 cycles, then dropped; valid with bus_err=1. A late ack 2 cycles later produces no extra valid.
- rst pulled low while in REQ -> mem_req=0 immediately, no valid. After release, SW addr=0x40, data=0x12345678, immediate ack -> wstrb=1111, valid 2 cycles after the request.

Source files
------------

// File: rtl/lsu_dmem_ctrl_if.sv
// Variable-latency req/ack data-memory port between the load/store unit and data memory.
// The LSU is the master: it drives the request fields and memory answers with rdata/ack.
interface lsu_dmem_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wstrb,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wstrb,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/lsu_dmem_ctrl.sv
// Load/store data-memory controller: aligns and strobes stores, extends loads and
// returns a one-cycle valid (with fault flags) that releases the core's stall.
module lsu_dmem_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        valid,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err,
  lsu_dmem_ctrl_if.master mem
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state_reg, state_next;

  logic        op_store_reg, op_store_next;
  logic [2:0]  funct3_reg, funct3_next;
  logic [1:0]  addr_lo_reg, addr_lo_next;
  logic        mis_reg, mis_next;
  logic        err_reg, err_next;
  logic [31:0] result_reg, result_next;
  logic [7:0]  cnt_reg, cnt_next;

  logic        valid_reg, valid_next;
  logic [31:0] load_data_reg, load_data_next;
  logic        misaligned_reg, misaligned_next;
  logic        bus_err_reg, bus_err_next;
  logic        mem_req_reg, mem_req_next;
  logic        mem_we_reg, mem_we_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [3:0]  mem_wstrb_reg, mem_wstrb_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;

  logic        accept;
  logic        f3_legal;
  logic        f3_mis;
  logic        req_illegal;
  logic        req_misal;
  logic        ack_seen;
  logic        timeout_hit;
  logic [3:0]  lane_strb;
  logic [31:0] lane_wdata;
  logic [7:0]  rbyte [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  // The valid cycle still carries the finished instruction, so it is not re-accepted.
  assign accept = (state_reg == IDLE) && (load || store) && !valid_reg;

  always_comb begin
    f3_legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = !store;
      default:                f3_legal = 1'b0;
    endcase
  end

  assign f3_mis      = ((funct3[1:0] == 2'b01) && addr[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  assign req_illegal = !f3_legal;
  assign req_misal   = f3_legal && f3_mis;

  assign ack_seen    = (state_reg == REQ) && mem.mem_ack;
  assign timeout_hit = (state_reg == REQ) && !mem.mem_ack && (cnt_reg == TMO_LAST);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign lane_strb[gi] = (funct3[1:0] == 2'b00) ? (addr[1:0] == LANE) :
                             (funct3[1:0] == 2'b01) ? (addr[1] == LANE[1]) :
                             1'b1;
      assign rbyte[gi] = mem.mem_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    case (funct3[1:0])
      2'b00:   lane_wdata = {4{store_data[7:0]}};
      2'b01:   lane_wdata = {2{store_data[15:0]}};
      default: lane_wdata = store_data;
    endcase
  end

  assign byte_sel = rbyte[addr_lo_reg];
  assign half_sel = addr_lo_reg[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

  always_comb begin
    case (funct3_reg)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = (req_illegal || req_misal) ? RESP : REQ;
        end
      end
      REQ: begin
        if (ack_seen || timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    op_store_next   = op_store_reg;
    funct3_next     = funct3_reg;
    addr_lo_next    = addr_lo_reg;
    mis_next        = mis_reg;
    err_next        = err_reg;
    result_next     = result_reg;
    cnt_next        = cnt_reg;
    mem_req_next    = mem_req_reg;
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wstrb_next  = mem_wstrb_reg;
    mem_wdata_next  = mem_wdata_reg;
    valid_next      = 1'b0;
    load_data_next  = 32'd0;
    misaligned_next = 1'b0;
    bus_err_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          op_store_next = store;
          funct3_next   = funct3;
          addr_lo_next  = addr[1:0];
          mis_next      = req_misal;
          err_next      = req_illegal;
          result_next   = 32'd0;
          cnt_next      = 8'd0;
          // Faulting instructions never touch the memory port.
          if (!req_illegal && !req_misal) begin
            mem_req_next   = 1'b1;
            mem_we_next    = store;
            mem_addr_next  = {addr[31:2], 2'b00};
            mem_wstrb_next = store ? lane_strb : 4'b0000;
            mem_wdata_next = store ? lane_wdata : 32'd0;
          end
        end
      end
      REQ: begin
        if (ack_seen) begin
          mem_req_next = 1'b0;
          mem_we_next  = 1'b0;
          result_next  = op_store_reg ? 32'd0 : load_ext;
        end else if (timeout_hit) begin
          mem_req_next = 1'b0;
          mem_we_next  = 1'b0;
          err_next     = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      RESP: begin
        valid_next      = 1'b1;
        load_data_next  = result_reg;
        misaligned_next = mis_reg;
        bus_err_next    = err_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_store_reg   <= 1'b0;
      funct3_reg     <= 3'd0;
      addr_lo_reg    <= 2'd0;
      mis_reg        <= 1'b0;
      err_reg        <= 1'b0;
      result_reg     <= 32'd0;
      cnt_reg        <= 8'd0;
      valid_reg      <= 1'b0;
      load_data_reg  <= 32'd0;
      misaligned_reg <= 1'b0;
      bus_err_reg    <= 1'b0;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= 32'd0;
      mem_wstrb_reg  <= 4'd0;
      mem_wdata_reg  <= 32'd0;
    end else begin
      op_store_reg   <= op_store_next;
      funct3_reg     <= funct3_next;
      addr_lo_reg    <= addr_lo_next;
      mis_reg        <= mis_next;
      err_reg        <= err_next;
      result_reg     <= result_next;
      cnt_reg        <= cnt_next;
      valid_reg      <= valid_next;
      load_data_reg  <= load_data_next;
      misaligned_reg <= misaligned_next;
      bus_err_reg    <= bus_err_next;
      mem_req_reg    <= mem_req_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wstrb_reg  <= mem_wstrb_next;
      mem_wdata_reg  <= mem_wdata_next;
    end
  end

  assign valid         = valid_reg;
  assign load_data     = load_data_reg;
  assign misaligned    = misaligned_reg;
  assign bus_err       = bus_err_reg;
  assign mem.mem_req   = mem_req_reg;
  assign mem.mem_we    = mem_we_reg;
  assign mem.mem_addr  = mem_addr_reg;
  assign mem.mem_wstrb = mem_wstrb_reg;
  assign mem.mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Directed bench for lsu_dmem_ctrl: loads, stores, faults, timeout and async reset abort.
module tb_lsu_dmem_ctrl;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;

  logic        clk;
  logic        rst;
  logic        load;
  logic        store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        valid;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_err;

  lsu_dmem_ctrl_if mem_if ();

  lsu_dmem_ctrl #(.TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .store      (store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .valid      (valid),
    .load_data  (load_data),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .mem        (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int valid_seen = 0;
  int req_seen = 0;
  int v0;
  int r0;

  // Running tallies of cycles with valid / mem_req high, sampled mid-cycle.
  always @(negedge clk) begin
    if (valid) valid_seen++;
    if (mem_if.mem_req) req_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; store = 1'b0; funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 32'd0;
    tick(); tick();
    chk1 ("rst_valid", valid, 1'b0);
    chk1 ("rst_req", mem_if.mem_req, 1'b0);
    chk1 ("rst_we", mem_if.mem_we, 1'b0);
    chk32("rst_addr", mem_if.mem_addr, 32'd0);
    chk32("rst_wstrb", {28'd0, mem_if.mem_wstrb}, 32'd0);
    chk32("rst_wdata", mem_if.mem_wdata, 32'd0);
    chk32("rst_ldata", load_data, 32'd0);
    rst = 1'b1;
    tick();

    // LW 0x100, ack 3 cycles after mem_req
    v0 = valid_seen; r0 = req_seen;
    load = 1'b1; funct3 = F_W; addr = 32'h100;
    tick();
    chk1 ("lw_req", mem_if.mem_req, 1'b1);
    chk1 ("lw_we", mem_if.mem_we, 1'b0);
    chk32("lw_addr", mem_if.mem_addr, 32'h100);
    tick(); tick();
    chk1 ("lw_req_held", mem_if.mem_req, 1'b1);
    chk1 ("lw_no_valid_yet", valid, 1'b0);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'hDEADBEEF;
    tick();
    mem_if.mem_ack = 1'b0;
    chk1 ("lw_req_drop", mem_if.mem_req, 1'b0);
    chk1 ("lw_valid_wait", valid, 1'b0);
    tick();
    chk1 ("lw_valid", valid, 1'b1);
    chk32("lw_data", load_data, 32'hDEADBEEF);
    chk1 ("lw_mis", misaligned, 1'b0);
    chk1 ("lw_err", bus_err, 1'b0);
    tick();
    load = 1'b0;
    chk1 ("lw_valid_drop", valid, 1'b0);
    chk32("lw_req_cycles", req_seen - r0, 32'd3);
    chk32("lw_valid_cycles", valid_seen - v0, 32'd1);

    // LB then LBU at 0x103, back to back
    load = 1'b1; funct3 = F_B; addr = 32'h103;
    tick();
    chk1 ("lb_req", mem_if.mem_req, 1'b1);
    chk32("lb_addr", mem_if.mem_addr, 32'h100);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h80FF_0000;
    tick();
    mem_if.mem_ack = 1'b0;
    tick();
    chk1 ("lb_valid", valid, 1'b1);
    chk32("lb_data", load_data, 32'hFFFFFF80);
    tick();
    chk1 ("lb_no_reaccept", mem_if.mem_req, 1'b0);
    funct3 = F_BU;
    tick();
    chk1 ("lbu_req", mem_if.mem_req, 1'b1);
    mem_if.mem_ack = 1'b1;
    tick();
    mem_if.mem_ack = 1'b0;
    tick();
    chk1 ("lbu_valid", valid, 1'b1);
    chk32("lbu_data", load_data, 32'h00000080);
    tick();
    load = 1'b0;

    // SH 0x202
    store = 1'b1; funct3 = F_H; addr = 32'h202; store_data = 32'h0000ABCD;
    tick();
    chk1 ("sh_req", mem_if.mem_req, 1'b1);
    chk1 ("sh_we", mem_if.mem_we, 1'b1);
    chk32("sh_addr", mem_if.mem_addr, 32'h200);
    chk32("sh_wstrb", {28'd0, mem_if.mem_wstrb}, 32'hC);
    chk32("sh_wdata", mem_if.mem_wdata, 32'hABCDABCD);
    mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h55555555;
    tick();
    mem_if.mem_ack = 1'b0;
    tick();
    chk1 ("sh_valid", valid, 1'b1);
    chk32("sh_ldata", load_data, 32'd0);
    tick();
    store = 1'b0;

    // Misaligned LW 0x101, then misaligned SH 0x3
    v0 = valid_seen; r0 = req_seen;
    load = 1'b1; funct3 = F_W; addr = 32'h101;
    tick();
    chk1 ("mlw_no_req", mem_if.mem_req, 1'b0);
    tick();
    chk1 ("mlw_valid", valid, 1'b1);
    chk1 ("mlw_mis", misaligned, 1'b1);
    chk1 ("mlw_err", bus_err, 1'b0);
    chk32("mlw_ldata", load_data, 32'd0);
    tick();
    chk1 ("mlw_mis_clear", misaligned, 1'b0);
    load = 1'b0; store = 1'b1; funct3 = F_H; addr = 32'h3; store_data = 32'h1234;
    tick();
    tick();
    chk1 ("msh_valid", valid, 1'b1);
    chk1 ("msh_mis", misaligned, 1'b1);
    tick();
    store = 1'b0;
    chk32("mis_no_req", req_seen - r0, 32'd0);
    chk32("mis_valid_cycles", valid_seen - v0, 32'd2);

    // Illegal store funct3 (100)
    store = 1'b1; funct3 = F_BU; addr = 32'h10;
    tick();
    chk1 ("ill_no_req", mem_if.mem_req, 1'b0);
    tick();
    chk1 ("ill_valid", valid, 1'b1);
    chk1 ("ill_err", bus_err, 1'b1);
    chk1 ("ill_mis", misaligned, 1'b0);
    tick();
    store = 1'b0;

    // Timeout: LW with no ack
    v0 = valid_seen; r0 = req_seen;
    load = 1'b1; funct3 = F_W; addr = 32'h10;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk1 ("tmo_req_last", mem_if.mem_req, 1'b1);
    tick();
    chk1 ("tmo_req_drop", mem_if.mem_req, 1'b0);
    tick();
    chk1 ("tmo_valid", valid, 1'b1);
    chk1 ("tmo_err", bus_err, 1'b1);
    tick();
    load = 1'b0;
    mem_if.mem_ack = 1'b1;
    tick();
    mem_if.mem_ack = 1'b0;
    tick(); tick();
    chk32("tmo_req_cycles", req_seen - r0, 32'd16);
    chk32("tmo_valid_cycles", valid_seen - v0, 32'd1);

    // Reset mid-REQ, then SW with immediate ack and a flushed store line
    load = 1'b1; funct3 = F_W; addr = 32'h20;
    tick(); tick();
    chk1 ("rreq_req", mem_if.mem_req, 1'b1);
    rst = 1'b0;
    #1;
    chk1 ("rreq_async_drop", mem_if.mem_req, 1'b0);
    v0 = valid_seen;
    load = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick(); tick();
    chk32("rreq_no_valid", valid_seen - v0, 32'd0);
    store = 1'b1; funct3 = F_W; addr = 32'h40; store_data = 32'h12345678;
    tick();
    chk1 ("sw_we", mem_if.mem_we, 1'b1);
    chk32("sw_addr", mem_if.mem_addr, 32'h40);
    chk32("sw_wstrb", {28'd0, mem_if.mem_wstrb}, 32'hF);
    chk32("sw_wdata", mem_if.mem_wdata, 32'h12345678);
    store = 1'b0;
    mem_if.mem_ack = 1'b1;
    tick();
    mem_if.mem_ack = 1'b0;
    tick();
    chk1 ("sw_valid", valid, 1'b1);
    chk32("sw_ldata", load_data, 32'd0);
    tick();
    chk1 ("sw_valid_drop", valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
